// File: rtl/line_memory.sv
// Single-port word memory moving whole lines in BEAT_WORDS-wide beats over a valid/ready handshake.
// Define LINE_MEM_WMASK_EN to add the per-word wr_mask port.
module line_memory #(
   parameter int WORD_W     = 32,
   parameter int DEPTH      = 512,
   parameter int LINE_WORDS = 16,
   parameter int BEAT_WORDS = 4,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int LINE_W    = WORD_W * LINE_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] wr_data,
`ifdef LINE_MEM_WMASK_EN
   input  logic [LINE_WORDS-1:0] wr_mask,
`endif
   output logic              wr_done,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [LINE_W-1:0] rd_data
);

   localparam int NBEATS = LINE_WORDS / BEAT_WORDS;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state_q, state_d;

   logic [BEAT_W-1:0] beat_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] line_buf;
   logic [LINE_W-1:0] buf_nxt;
   logic              last_beat;
   int                base;

   logic [ADDR_W-1:0]     beat_addr  [BEAT_WORDS];
   logic [WORD_W-1:0]     beat_wdata [BEAT_WORDS];
   logic [BEAT_WORDS-1:0] beat_we;

   logic [WORD_W-1:0] mem [DEPTH];

`ifdef LINE_MEM_WMASK_EN
   logic [LINE_WORDS-1:0] mask_q;
`endif

   assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

   // Word j of the line sits MSB-first; address arithmetic wraps at DEPTH.
   always_comb begin
      base    = int'(beat_q) * BEAT_WORDS;
      buf_nxt = line_buf;
      beat_we = '1;
      for (int k = 0; k < BEAT_WORDS; k++) begin
         beat_addr[k]  = addr_q + ADDR_W'(base + k);
         beat_wdata[k] = wdata_q[LINE_W-1-(base+k)*WORD_W -: WORD_W];
`ifdef LINE_MEM_WMASK_EN
         beat_we[k]    = mask_q[base+k];
`endif
         buf_nxt[LINE_W-1-(base+k)*WORD_W -: WORD_W] = mem[beat_addr[k]];
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rd_valid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ACCESS;
         end
         ACCESS: begin
            if (last_beat) state_d = write_q ? IDLE : RESP;
         end
         RESP: begin
            rd_valid = 1'b1;
            if (rd_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q   <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         line_buf <= '0;
         rd_data  <= '0;
         wr_done  <= 1'b0;
`ifdef LINE_MEM_WMASK_EN
         mask_q   <= '0;
`endif
      end else begin
         wr_done <= 1'b0;
         if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= wr_data;
            beat_q  <= '0;
`ifdef LINE_MEM_WMASK_EN
            mask_q  <= wr_mask;
`endif
         end
         if (state_q == ACCESS) begin
            beat_q   <= beat_q + 1'b1;
            line_buf <= buf_nxt;
            if (last_beat) begin
               beat_q <= '0;
               if (write_q) wr_done <= 1'b1;
               else         rd_data <= buf_nxt;
            end
         end
      end
   end

   // Storage is not reset; a reset cycle blocks the pending beat.
   always_ff @(posedge clk) begin
      if (!rst && state_q == ACCESS && write_q) begin
         for (int k = 0; k < BEAT_WORDS; k++) begin
            if (beat_we[k]) mem[beat_addr[k]] <= beat_wdata[k];
         end
      end
   end

endmodule
